// File: rtl/ifid_ctrl_pkg.sv
// Shared definitions for the IF/ID pipeline controller.
// Holds the FSM encoding, the NOP word, the opcodes that read rt, and the instruction field positions.
package ifid_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_IMISS = 1'b1
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  // True for opcodes whose rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_R_TYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ifid_ctrl_if.sv
// Bundle of datapath status inputs and stage-register controls for ifid_ctrl.
// master is the datapath side, slave is the controller side.
interface ifid_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [31:0]      ifid_instr;
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             imem_ready;

  logic             pc_write;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_count;
  logic             state;

  modport master (
    output ifid_instr, idex_mem_read, idex_rt, branch_taken, branch_target, imem_ready,
    input  pc_write, redirect_valid, redirect_pc, ifid_write, ifid_flush, idex_bubble,
           stall_count, state
  );

  modport slave (
    input  ifid_instr, idex_mem_read, idex_rt, branch_taken, branch_target, imem_ready,
    output pc_write, redirect_valid, redirect_pc, ifid_write, ifid_flush, idex_bubble,
           stall_count, state
  );

endinterface

// File: rtl/ifid_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources of the IF/ID instruction.
// Purely combinational; rt is only treated as a source for opcodes that actually read it.
module ifid_hazard_detect
  import ifid_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic        i_mem_read,
  input  logic [4:0]  i_rt,
  output logic        o_hazard
);

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_rs_hit;
  logic       w_rt_hit;
  logic       w_unused_bits;

  assign w_op = i_instr[OP_HI:OP_LO];
  assign w_rs = i_instr[RS_HI:RS_LO];
  assign w_rt = i_instr[RT_HI:RT_LO];

  // Immediate/rd/shamt/funct bits play no part in the hazard decision.
  assign w_unused_bits = &{1'b0, i_instr[15:0]};

  assign w_rs_hit = (i_rt == w_rs);
  assign w_rt_hit = uses_rt(w_op) && (i_rt == w_rt);

  // $zero is never a real dependency, so a load targeting it never stalls.
  assign o_hazard = i_mem_read && (i_rt != 5'd0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/ifid_ctrl.sv
// IF/ID and PC controller: load-use stalls, branch squash, and instruction-miss redirect sequencing.
// All controls are combinational from state, pending-redirect registers and current inputs.
module ifid_ctrl
  import ifid_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic   clk,
  input  logic   reset,
  ifid_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pend;
  logic             w_pend_nxt;
  logic [31:0]      r_pend_pc;
  logic [31:0]      w_pend_pc_nxt;
  logic [CNT_W-1:0] r_stall_count;

  logic             w_hazard;
  logic             w_pc_write;
  logic             w_redirect_valid;
  logic [31:0]      w_redirect_pc;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic             w_idex_bubble;

  ifid_hazard_detect u_hazard (
    .i_instr    (bus.ifid_instr),
    .i_mem_read (bus.idex_mem_read),
    .i_rt       (bus.idex_rt),
    .o_hazard   (w_hazard)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending redirect captured while a fetch is outstanding; reset drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= 1'b0;
      r_pend_pc <= 32'h0;
    end else begin
      r_pend    <= w_pend_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (!w_pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  // Next state and pending-redirect update.
  always_comb begin
    w_state_nxt   = r_state;
    w_pend_nxt    = r_pend;
    w_pend_pc_nxt = r_pend_pc;
    case (r_state)
      ST_RUN: begin
        // A taken branch wins over a miss: the redirected fetch starts next cycle.
        if (!bus.branch_taken && !bus.imem_ready) begin
          w_state_nxt = ST_IMISS;
        end
      end
      ST_IMISS: begin
        if (bus.imem_ready) begin
          w_state_nxt = ST_RUN;
          w_pend_nxt  = 1'b0;
        end else if (bus.branch_taken && !r_pend) begin
          // Only the first redirect seen during a miss is kept; it is the older one.
          w_pend_nxt    = 1'b1;
          w_pend_pc_nxt = bus.branch_target;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Control outputs for the current cycle, with reset forcing a safe squash.
  always_comb begin
    w_pc_write       = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 32'h0;
    w_ifid_write     = 1'b0;
    w_ifid_flush     = 1'b0;
    w_idex_bubble    = 1'b0;
    if (reset) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.branch_taken) begin
            w_pc_write       = 1'b1;
            w_redirect_valid = 1'b1;
            w_redirect_pc    = bus.branch_target;
            w_ifid_flush     = 1'b1;
            w_idex_bubble    = 1'b1;
          end else if (!bus.imem_ready) begin
            w_ifid_flush = 1'b1;
          end else if (w_hazard) begin
            // Bubble clears the load from ID/EX, so this stall lasts one cycle.
            w_idex_bubble = 1'b1;
          end else begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
          end
        end
        ST_IMISS: begin
          w_ifid_flush = 1'b1;
          if (bus.imem_ready) begin
            w_pc_write = 1'b1;
            if (bus.branch_taken || r_pend) begin
              // Returned word is wrong-path; discard it and redirect.
              w_redirect_valid = 1'b1;
              w_redirect_pc    = bus.branch_taken ? bus.branch_target : r_pend_pc;
              w_idex_bubble    = bus.branch_taken;
            end else begin
              w_ifid_write = 1'b1;
              w_ifid_flush = 1'b0;
            end
          end else begin
            w_idex_bubble = bus.branch_taken;
          end
        end
        default: begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_write       = w_pc_write;
  assign bus.redirect_valid = w_redirect_valid;
  assign bus.redirect_pc    = w_redirect_pc;
  assign bus.ifid_write     = w_ifid_write;
  assign bus.ifid_flush     = w_ifid_flush;
  assign bus.idex_bubble    = w_idex_bubble;
  assign bus.stall_count    = r_stall_count;
  assign bus.state          = r_state;

endmodule

// File: tb/tb_ifid_ctrl.sv
// Bench for ifid_ctrl: table of per-cycle vectors plus hand sequences for miss/redirect and saturation.
// A second instance with a 4-bit counter shares the same stimulus to exercise saturation.
module tb_ifid_ctrl;

  localparam logic [31:0] I_ADD = 32'h0109_5020;  // add $10,$8,$9
  localparam logic [31:0] I_LW  = 32'h8D09_0004;  // lw  $9,4($8)

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        mr;
    logic [4:0]  rt;
    logic        bt;
    logic [31:0] tgt;
    logic        rdy;
    logic        pcw;
    logic        rv;
    logic [31:0] rpc;
    logic        ifw;
    logic        fl;
    logic        bub;
    logic        st;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  ifid_ctrl_if #(.CNT_W(16)) bus ();
  ifid_ctrl_if #(.CNT_W(4))  bus4 ();

  ifid_ctrl #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  ifid_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  assign bus4.ifid_instr    = bus.ifid_instr;
  assign bus4.idex_mem_read = bus.idex_mem_read;
  assign bus4.idex_rt       = bus.idex_rt;
  assign bus4.branch_taken  = bus.branch_taken;
  assign bus4.branch_target = bus.branch_target;
  assign bus4.imem_ready    = bus.imem_ready;

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t tbl[26];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got 0x%0h want 0x%0h", nm, idx, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs of this cycle.
  task automatic check_head(input int idx);
    vec_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", idx, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pc_write",       idx, {31'd0, bus.pc_write},       {31'd0, e.pcw});
      chk("redirect_valid", idx, {31'd0, bus.redirect_valid}, {31'd0, e.rv});
      chk("redirect_pc",    idx, bus.redirect_pc,             e.rpc);
      chk("ifid_write",     idx, {31'd0, bus.ifid_write},     {31'd0, e.ifw});
      chk("ifid_flush",     idx, {31'd0, bus.ifid_flush},     {31'd0, e.fl});
      chk("idex_bubble",    idx, {31'd0, bus.idex_bubble},    {31'd0, e.bub});
      chk("state",          idx, {31'd0, bus.state},          {31'd0, e.st});
      chk("stall_count",    idx, {16'd0, bus.stall_count},    {16'd0, e.cnt});
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then check before the next rising edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset             = v.rst;
    bus.ifid_instr    = v.instr;
    bus.idex_mem_read = v.mr;
    bus.idex_rt       = v.rt;
    bus.branch_taken  = v.bt;
    bus.branch_target = v.tgt;
    bus.imem_ready    = v.rdy;
    sb.push_back(v);
    #2;
    check_head(idx);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //          rst   instr  mr   rt    bt   tgt            rdy | pcw  rv   rpc            ifw  fl   bub  st   cnt
    tbl[0]  = '{1'b1, I_ADD, 1'b0, 5'd0, 1'b1, 32'h0040_0100, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, I_ADD, 1'b0, 5'd0, 1'b1, 32'h0040_0100, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, I_ADD, 1'b1, 5'd9, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, I_ADD, 1'b0, 5'd9, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[5]  = '{1'b0, I_ADD, 1'b1, 5'd0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[6]  = '{1'b0, I_ADD, 1'b1, 5'd8, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[7]  = '{1'b0, I_LW,  1'b1, 5'd9, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[8]  = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b1, 32'h0040_0100, 1'b1, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
    tbl[9]  = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b1, 32'h0040_0300, 1'b0, 1'b1, 1'b1, 32'h0040_0300, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
    tbl[10] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[11] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b1, 32'h0040_0200, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 16'd3};
    tbl[12] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b1, 32'h0040_0400, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 16'd4};
    tbl[13] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 16'd5};
    tbl[14] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0040_0200, 1'b0, 1'b1, 1'b0, 1'b1, 16'd6};
    tbl[15] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd6};
    tbl[16] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 16'd6};
    tbl[17] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b1, 32'h0040_0500, 1'b1, 1'b1, 1'b1, 32'h0040_0500, 1'b0, 1'b1, 1'b1, 1'b1, 16'd7};
    tbl[18] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 16'd7};
    tbl[19] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 16'd8};
    tbl[20] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 16'd8};
    tbl[21] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b1, 32'h0040_0600, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 16'd9};
    tbl[22] = '{1'b1, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 16'd10};
    tbl[23] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[24] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
    tbl[25] = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0, 16'd1};

    // First reset cycle: registers are still unknown, so nothing is checked yet.
    reset             = 1'b1;
    bus.ifid_instr    = I_ADD;
    bus.idex_mem_read = 1'b0;
    bus.idex_rt       = 5'd0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0040_0100;
    bus.imem_ready    = 1'b1;

    for (int i = 0; i < 26; i++) begin
      apply(tbl[i], i);
    end

    // Miss for three cycles with a redirect arriving in the second one.
    v = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 16'd1}; apply(v, 100);
    v = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b1, 32'h0040_0200, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 16'd2}; apply(v, 101);
    v = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 16'd3}; apply(v, 102);
    v = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0040_0200, 1'b0, 1'b1, 1'b0, 1'b1, 16'd4}; apply(v, 103);
    v = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 16'd4}; apply(v, 104);

    // Twenty miss cycles: the 16-bit counter keeps going, the 4-bit one pins at 15.
    for (int i = 0; i < 20; i++) begin
      v = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0,
            (i != 0), 16'(4 + i)};
      apply(v, 200 + i);
      if (i == 10) begin
        chk("stall_count_w4_mid", 200 + i, {28'd0, bus4.stall_count}, 32'd14);
      end
    end
    v = '{1'b0, I_ADD, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd24};
    apply(v, 220);
    chk("stall_count_w4_sat", 220, {28'd0, bus4.stall_count}, 32'd15);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
